// File: rtl/traffic_pkg.sv
// Shared lamp encodings, state/axis types and pattern helpers for the lamp sequencer.
// FLASH_ON_ERROR_EN adds the FAULT state to the state enum.
package traffic_pkg;

    localparam logic [1:0] LAMP_RED = 2'b00;
    localparam logic [1:0] LAMP_YEL = 2'b01;
    localparam logic [1:0] LAMP_GRN = 2'b11;

    // Lane vectors are WWSSEENN, two bits per direction.
    localparam logic [7:0] LANE_NS   = {LAMP_RED, LAMP_GRN, LAMP_RED, LAMP_GRN};
    localparam logic [7:0] LANE_EW   = {LAMP_GRN, LAMP_RED, LAMP_GRN, LAMP_RED};
    localparam logic [7:0] YEL_NS    = {LAMP_RED, LAMP_YEL, LAMP_RED, LAMP_YEL};
    localparam logic [7:0] YEL_EW    = {LAMP_YEL, LAMP_RED, LAMP_YEL, LAMP_RED};
    localparam logic [7:0] FLASH_YEL = {LAMP_YEL, LAMP_YEL, LAMP_YEL, LAMP_YEL};
    localparam logic [7:0] ALL_RED   = 8'h00;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_CLEAR,
        ST_GREEN,
        ST_YELLOW
`ifdef FLASH_ON_ERROR_EN
        , ST_FAULT
`endif
    } state_e;

    typedef enum logic {
        AXIS_NS,
        AXIS_EW
    } axis_e;

    function automatic logic [7:0] green_lamps(input axis_e a);
        return (a == AXIS_NS) ? LANE_NS : LANE_EW;
    endfunction

    function automatic logic [7:0] yellow_lamps(input axis_e a);
        return (a == AXIS_NS) ? YEL_NS : YEL_EW;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Per-state dwell counter: synchronous clear, saturating increment, async reset to 0.
module dwell_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr)
            cnt_d = '0;
        else if (&cnt_q)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/lamp_sequencer.sv
// Lamp sequencer: turns WWSSEENN lane requests into a safe green/yellow/all-red lamp sequence.
// Define FLASH_ON_ERROR_EN to latch a flashing FAULT after three consecutive illegal requests.
module lamp_sequencer
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN     = 4,
    parameter int YELLOW_CYCLES = 3,
    parameter int CLEAR_CYCLES  = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] laneRequest,
    output logic [7:0] lampOut,
    output logic       axisNS,
    output logic       busy,
    output logic       reqError,
    output logic       faultFlag
);

    localparam int CNT_MAX = (2 ** CNT_W) - 1;

    if (MIN_GREEN < 1 || MIN_GREEN > CNT_MAX ||
        YELLOW_CYCLES < 1 || YELLOW_CYCLES > CNT_MAX ||
        CLEAR_CYCLES < 1 || CLEAR_CYCLES > CNT_MAX) begin : g_bad_dwell
        $error("lamp_sequencer: dwell parameters must lie in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    state_e           state_q, state_d;
    axis_e            next_axis_q, next_axis_d;
    axis_e            active_axis_q, active_axis_d;
    logic [7:0]       lamp_q, lamp_d;
    logic             axis_ns_q, axis_ns_d;
    logic             busy_q, busy_d;
    logic             req_err_q, req_err_d;
    logic [CNT_W-1:0] cnt;
    logic             legal;
    axis_e            req_axis;
`ifdef FLASH_ON_ERROR_EN
    logic [1:0]       ill_cnt_q, ill_cnt_d;
    logic             fault_q, fault_d;
`endif

    dwell_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (state_d != state_q),
        .cnt (cnt)
    );

    assign legal    = (laneRequest == LANE_NS) || (laneRequest == LANE_EW);
    assign req_axis = (laneRequest == LANE_NS) ? AXIS_NS : AXIS_EW;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        next_axis_d   = next_axis_q;
        active_axis_d = active_axis_q;
        req_err_d     = !legal;

        case (state_q)
            ST_INIT: begin
                if (legal) begin
                    next_axis_d = req_axis;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (cnt == CLR_LAST) begin
                    active_axis_d = next_axis_q;
                    state_d       = ST_GREEN;
                end
            end
            ST_GREEN: begin
                // A too-early change request is a level: it wins once minimum green has elapsed.
                if (legal && req_axis != active_axis_q && cnt >= MIN_LAST) begin
                    next_axis_d = req_axis;
                    state_d     = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (cnt == YEL_LAST)
                    state_d = ST_CLEAR;
            end
            default: state_d = ST_INIT;
        endcase

`ifdef FLASH_ON_ERROR_EN
        ill_cnt_d = ill_cnt_q;
        if (legal)
            ill_cnt_d = 2'd0;
        else if (ill_cnt_q != 2'd2)
            ill_cnt_d = ill_cnt_q + 2'd1;
        if ((!legal && ill_cnt_q == 2'd2) || state_q == ST_FAULT)
            state_d = ST_FAULT;
        fault_d = fault_q || (state_d == ST_FAULT);
`endif

        // Outputs are decoded from the next state so they change on the same edge as the state.
        lamp_d    = ALL_RED;
        axis_ns_d = 1'b0;
        busy_d    = 1'b0;
        case (state_d)
            ST_GREEN: begin
                lamp_d    = green_lamps(active_axis_d);
                axis_ns_d = (active_axis_d == AXIS_NS);
            end
            ST_YELLOW: begin
                lamp_d = yellow_lamps(active_axis_d);
                busy_d = 1'b1;
            end
            ST_CLEAR: busy_d = 1'b1;
`ifdef FLASH_ON_ERROR_EN
            ST_FAULT: lamp_d = (state_q == ST_FAULT && lamp_q == FLASH_YEL) ? ALL_RED : FLASH_YEL;
`endif
            default: ;
        endcase
    end

    // NOTE: all control flops, including axis memory, reset asynchronously to a known safe state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_INIT;
            next_axis_q   <= AXIS_EW;
            active_axis_q <= AXIS_EW;
            lamp_q        <= ALL_RED;
            axis_ns_q     <= 1'b0;
            busy_q        <= 1'b0;
            req_err_q     <= 1'b0;
`ifdef FLASH_ON_ERROR_EN
            ill_cnt_q     <= 2'd0;
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            next_axis_q   <= next_axis_d;
            active_axis_q <= active_axis_d;
            lamp_q        <= lamp_d;
            axis_ns_q     <= axis_ns_d;
            busy_q        <= busy_d;
            req_err_q     <= req_err_d;
`ifdef FLASH_ON_ERROR_EN
            ill_cnt_q     <= ill_cnt_d;
            fault_q       <= fault_d;
`endif
        end
    end

    assign lampOut  = lamp_q;
    assign axisNS   = axis_ns_q;
    assign busy     = busy_q;
    assign reqError = req_err_q;
`ifdef FLASH_ON_ERROR_EN
    assign faultFlag = fault_q;
`else
    assign faultFlag = 1'b0;
`endif

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed bench for lamp_sequencer: a vector table for the main sequence plus hand-written
// reset-in-yellow sequence; expectations follow FLASH_ON_ERROR_EN when it is defined.
module tb_lamp_sequencer;

    localparam logic [7:0] NS  = 8'b00110011;
    localparam logic [7:0] EW  = 8'b11001100;
    localparam logic [7:0] YNS = 8'b00010001;
    localparam logic [7:0] YEW = 8'b01000100;
    localparam logic [7:0] FLS = 8'b01010101;
    localparam logic [7:0] RED = 8'h00;

    typedef struct {
        logic [7:0] req;
        logic [7:0] lamp;
        logic       ns;
        logic       busy;
        logic       err;
        logic       flt;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] laneRequest;
    logic [7:0] lampOut;
    logic       axisNS;
    logic       busy;
    logic       reqError;
    logic       faultFlag;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    lamp_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .laneRequest (laneRequest),
        .lampOut     (lampOut),
        .axisNS      (axisNS),
        .busy        (busy),
        .reqError    (reqError),
        .faultFlag   (faultFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] req, input logic [7:0] lamp,
                                input logic ns, input logic bsy, input logic err, input logic flt);
        vec_t v;
        v.req = req; v.lamp = lamp; v.ns = ns; v.busy = bsy; v.err = err; v.flt = flt;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] lamp, input logic ns,
                         input logic bsy, input logic err, input logic flt);
        checks++;
        if ({lampOut, axisNS, busy, reqError, faultFlag} !== {lamp, ns, bsy, err, flt}) begin
            errors++;
            $display("FAIL %s: got lamp=%b ns=%b busy=%b err=%b flt=%b, want lamp=%b ns=%b busy=%b err=%b flt=%b",
                     name, lampOut, axisNS, busy, reqError, faultFlag, lamp, ns, bsy, err, flt);
        end
    endtask

    // Called just after a falling edge: drive, let the rising edge sample, check, return at next fall.
    task automatic step(input string name, input vec_t v);
        laneRequest = v.req;
        @(posedge clk);
        #1;
        check(name, v.lamp, v.ns, v.busy, v.err, v.flt);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        laneRequest = EW;

        // INIT -> 2 CLEAR -> EW green, then a long EW green.
        tbl.push_back(mk(EW, RED, 0, 1, 0, 0));
        tbl.push_back(mk(EW, RED, 0, 1, 0, 0));
        tbl.push_back(mk(EW, EW,  0, 0, 0, 0));
        for (int i = 0; i < 9; i++) tbl.push_back(mk(EW, EW, 0, 0, 0, 0));
        // Held NS request: yellow x3, clear x2, NS green.
        tbl.push_back(mk(NS, YEW, 0, 1, 0, 0));
        tbl.push_back(mk(NS, YEW, 0, 1, 0, 0));
        tbl.push_back(mk(NS, YEW, 0, 1, 0, 0));
        tbl.push_back(mk(NS, RED, 0, 1, 0, 0));
        tbl.push_back(mk(NS, RED, 0, 1, 0, 0));
        tbl.push_back(mk(NS, NS,  1, 0, 0, 0));
        // Single illegal sample in NS green, then minimum-green boundary for the EW request.
        tbl.push_back(mk(8'hFF, NS, 1, 0, 1, 0));
        tbl.push_back(mk(NS, NS,  1, 0, 0, 0));
        tbl.push_back(mk(EW, NS,  1, 0, 0, 0));
        tbl.push_back(mk(EW, YNS, 0, 1, 0, 0));
        tbl.push_back(mk(8'h5A, YNS, 0, 1, 1, 0));
        tbl.push_back(mk(EW, YNS, 0, 1, 0, 0));
        tbl.push_back(mk(EW, RED, 0, 1, 0, 0));
        tbl.push_back(mk(EW, RED, 0, 1, 0, 0));
        tbl.push_back(mk(EW, EW,  0, 0, 0, 0));
        // Short NS blip early in EW green is ignored.
        tbl.push_back(mk(EW, EW,  0, 0, 0, 0));
        tbl.push_back(mk(NS, EW,  0, 0, 0, 0));
        tbl.push_back(mk(EW, EW,  0, 0, 0, 0));
        tbl.push_back(mk(EW, EW,  0, 0, 0, 0));
        tbl.push_back(mk(EW, EW,  0, 0, 0, 0));
        // Three consecutive illegal samples in green.
        tbl.push_back(mk(RED, EW, 0, 0, 1, 0));
        tbl.push_back(mk(RED, EW, 0, 0, 1, 0));
`ifdef FLASH_ON_ERROR_EN
        tbl.push_back(mk(RED, FLS, 0, 0, 1, 1));
        tbl.push_back(mk(EW,  RED, 0, 0, 0, 1));
        tbl.push_back(mk(EW,  FLS, 0, 0, 0, 1));
`else
        tbl.push_back(mk(RED, EW, 0, 0, 1, 0));
        tbl.push_back(mk(EW,  EW, 0, 0, 0, 0));
        tbl.push_back(mk(EW,  EW, 0, 0, 0, 0));
`endif

        #2;
        check("reset_state", RED, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // Fresh reset, illegal in INIT, then asynchronous reset in the middle of yellow.
        rst = 1'b1;
        #1;
        check("rst_async_1", RED, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        step("init_illegal", mk(8'hFF, RED, 0, 0, 1, 0));
        step("init_clear0",  mk(EW, RED, 0, 1, 0, 0));
        step("init_clear1",  mk(EW, RED, 0, 1, 0, 0));
        step("init_green0",  mk(EW, EW,  0, 0, 0, 0));
        step("init_green1",  mk(EW, EW,  0, 0, 0, 0));
        step("init_green2",  mk(EW, EW,  0, 0, 0, 0));
        step("init_green3",  mk(EW, EW,  0, 0, 0, 0));
        step("yel0",         mk(NS, YEW, 0, 1, 0, 0));
        step("yel1",         mk(NS, YEW, 0, 1, 0, 0));
        rst = 1'b1;
        #1;
        check("rst_mid_yellow", RED, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        step("restart_clear0", mk(EW, RED, 0, 1, 0, 0));
        step("restart_clear1", mk(EW, RED, 0, 1, 0, 0));
        step("restart_green",  mk(EW, EW,  0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lamp_sequencer.md
Name: lamp_sequencer

Overview:
- Receiving end of the lane-state interface. It accepts the 8-bit WWSSEENN lane request produced by the day and night controllers and drives the physical lamp vector.
- It enforces a safe change sequence on every axis change: minimum green, then yellow, then all-red clearance, then the new green.
- It sits between the mode controllers and the lamp outputs, and flags malformed requests.

Parameters:
- MIN_GREEN, 4, minimum cycles a green axis is displayed before a change is honoured.
- YELLOW_CYCLES, 3, exact cycles the yellow phase is displayed.
- CLEAR_CYCLES, 2, exact cycles the all-red clearance is displayed.
- CNT_W, 4, dwell counter width. All three dwell parameters must be between 1 and 2^CNT_W-1 inclusive; elaboration error otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- laneRequest  input  8  requested state, WWSSEENN. Legal values are 8'b00110011 (NS) and 8'b11001100 (EW).
- lampOut  output  8  lamp drive, WWSSEENN, 2 bits per direction: 11 green, 01 yellow, 00 red, 10 never driven.
- axisNS  output  1  1 while NS is green; 0 otherwise.
- busy  output  1  1 during YELLOW or CLEAR.
- reqError  output  1  one-cycle pulse for each cycle laneRequest is illegal while it is being sampled.
- faultFlag  output  1  latched fault; tied 0 when the optional feature is compiled out.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, not on the next clk edge):
  - lampOut=8'h00, axisNS=0, busy=0, reqError=0, faultFlag=0.
  - state=INIT, counter=0, nextAxis=EW.
- States: INIT, CLEAR, GREEN, YELLOW, plus FAULT when the optional feature is enabled.
- The counter clears on every state entry and increments once per cycle while in the state.
- INIT:
  - lampOut=00.
  - First legal request: latch nextAxis from the request and go to CLEAR.
  - Illegal request: pulse reqError, stay in INIT.
- CLEAR:
  - lampOut=00, busy=1.
  - When counter==CLEAR_CYCLES-1, go to GREEN with activeAxis=nextAxis.
- GREEN:
  - lampOut = pattern for activeAxis. axisNS=1 if activeAxis is NS.
  - Legal request for the other axis and counter>=MIN_GREEN-1: latch nextAxis = other axis, go to YELLOW.
  - Legal request for the other axis earlier than that: no action. It is re-evaluated each cycle as a level.
  - Request equal to the active axis: stay. The counter saturates at all-ones.
  - Illegal request: pulse reqError, hold state.
- YELLOW:
  - The activeAxis directions show 01, the others 00 (EW = 01000100, NS = 00010001). busy=1.
  - When counter==YELLOW_CYCLES-1, go to CLEAR.
- During YELLOW and CLEAR, laneRequest is ignored, except that the illegal-value check still pulses reqError.
- Latency: the lamp change appears on the clk edge after the qualifying request is sampled.
  - Minimum visible durations: green MIN_GREEN cycles, yellow exactly YELLOW_CYCLES, clear exactly CLEAR_CYCLES.
- Invariant: both axes are never non-red in the same cycle. The unused code 10 is never emitted.

Optional Feature:
- Macro: FLASH_ON_ERROR_EN.
- Defined:
  - A 2-bit counter tracks consecutive illegal samples.
  - A third consecutive illegal sample, in any state, enters FAULT on the next edge and sets faultFlag=1 (latched).
  - In FAULT, lampOut alternates 01010101 / 00000000 each cycle, starting with 01010101. axisNS=0, busy=0.
  - FAULT is left only by rst.
  - Any legal sample clears the consecutive-illegal counter.
- Undefined: illegal requests only pulse reqError, FAULT does not exist, faultFlag is constant 0.

Decomposition:
- Package traffic_pkg:
  - Lane constants LANE_NS=8'b00110011, LANE_EW=8'b11001100, YEL_NS=8'b00010001, YEL_EW=8'b01000100, FLASH_YEL=8'b01010101, ALL_RED=8'h00.
  - Direction code constants LAMP_RED, LAMP_YEL, LAMP_GRN.
  - State enum and axis type.
- Sub-module dwell_counter:
  - CNT_W-bit counter with synchronous clear, saturating increment, and asynchronous reset to 0.
  - Instantiated once; the sequencer compares its value against the dwell parameters.

Test Plan:
1. Release rst, hold laneRequest=11001100 → lampOut=00 for 1 INIT + 2 CLEAR cycles, then 11001100 with axisNS=0.
2. Steady EW green for 10 cycles, then request 00110011 held → green stays; next cycles show 01000100 ×3, 00000000 ×2, then 00110011 with axisNS=1.
3. EW green entered, request NS on the 2nd green cycle only, then back to EW → no yellow, lampOut stays 11001100.
4. During NS green, laneRequest=8'hFF for 1 cycle → reqError high for exactly 1 cycle, lampOut unchanged at 00110011.
5. Assert rst mid-YELLOW (between clk edges) → lampOut=00, busy=0 immediately. After release, the sequence restarts from INIT as in scenario 1.
6. With FLASH_ON_ERROR_EN: three consecutive 8'h00 requests in GREEN → faultFlag=1, lampOut alternates 01010101/00000000. A later legal 11001100 is ignored until rst. Without the macro: the same stimulus gives 3 reqError pulses and green continues.
